// File: rtl/spi_host_if.sv
// Byte-stream and frame-control bundle between an SPI initiator and its controller.
interface spi_host_if;
  logic       start_i;
  logic [7:0] len_i;
  logic       ready_o;
  logic       busy_o;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       done_o;

  modport slave (
    input  start_i, len_i, tx_data_i, tx_valid_i,
    output ready_o, busy_o, tx_ready_o, rx_data_o, rx_valid_o, done_o
  );

  modport master (
    output start_i, len_i, tx_data_i, tx_valid_i,
    input  ready_o, busy_o, tx_ready_o, rx_data_o, rx_valid_o, done_o
  );
endinterface

// File: rtl/spi_host.sv
// SPI initiator, CPOL=0 / CPHA=1, MSB first, 8-bit words, active-low CS.
// A frame of len_i+1 bytes is fed through a valid/ready stream; MISO bytes come back on a strobe.
module spi_host #(
  parameter int unsigned CLK_DIV = 8,
  parameter int unsigned CS_GAP  = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  spi_host_if.slave  bus,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_cs,
  input  logic       spi_miso
);

  localparam int unsigned CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int unsigned CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] DIV_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_END = CW'(CS_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_BYTE, S_SHIFT_HI, S_SHIFT_LO, S_HOLD, S_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    byte_q, byte_d;
  logic [7:0]    txsh_q, txsh_d;
  logic [7:0]    rxsh_q, rxsh_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          cs_q, cs_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          txrdy_q, txrdy_d;
  logic [7:0]    rxdata_q, rxdata_d;
  logic          rxvld_q, rxvld_d;
  logic          done_q, done_d;

  logic accept;
  logic handshake;
  logic div_end;

  assign accept    = bus.start_i && ready_q;
  assign handshake = bus.tx_valid_i && txrdy_q;
  assign div_end   = (div_q == DIV_END);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // WAIT_BYTE doubles as the pre-SCLK delay: once tx_ready drops the divider runs to the first rise.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (accept) state_d = S_WAIT_BYTE;
      S_WAIT_BYTE: if (!txrdy_q && div_end) state_d = S_SHIFT_HI;
      S_SHIFT_HI:  if (div_end) state_d = S_SHIFT_LO;
      S_SHIFT_LO: begin
        if (bit_q == 3'd7)  state_d = (byte_q != 8'd0) ? S_WAIT_BYTE : S_HOLD;
        else if (div_end)   state_d = S_SHIFT_HI;
      end
      S_HOLD:      if (div_end) state_d = S_GAP;
      S_GAP:       if (div_q == GAP_END) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    div_d    = div_q + CW'(1);
    bit_d    = bit_q;
    byte_d   = byte_q;
    txsh_d   = txsh_q;
    rxsh_d   = rxsh_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    cs_d     = cs_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    txrdy_d  = txrdy_q;
    rxdata_d = rxdata_q;
    rxvld_d  = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (accept) begin
          byte_d  = bus.len_i;
          cs_d    = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          txrdy_d = 1'b1;
        end
      end
      S_WAIT_BYTE: begin
        if (handshake) begin
          txsh_d  = bus.tx_data_i;
          bit_d   = '0;
          txrdy_d = 1'b0;
          div_d   = CW'(1);
        end else if (txrdy_q) begin
          div_d = div_q;
        end else if (div_end) begin
          sclk_d = 1'b1;
          mosi_d = txsh_q[7];
          div_d  = '0;
        end
      end
      S_SHIFT_HI: begin
        if (div_end) begin
          sclk_d = 1'b0;
          rxsh_d = {rxsh_q[6:0], spi_miso};
          div_d  = '0;
        end
      end
      S_SHIFT_LO: begin
        if (bit_q == 3'd7) begin
          rxdata_d = rxsh_q;
          rxvld_d  = 1'b1;
          if (byte_q != 8'd0) begin
            byte_d  = byte_q - 8'd1;
            txrdy_d = 1'b1;
          end else begin
            div_d = CW'(1);
          end
        end else if (div_end) begin
          txsh_d = {txsh_q[6:0], 1'b0};
          mosi_d = txsh_q[6];
          sclk_d = 1'b1;
          bit_d  = bit_q + 3'd1;
          div_d  = '0;
        end
      end
      S_HOLD: begin
        if (div_end) begin
          cs_d   = 1'b1;
          done_d = 1'b1;
          div_d  = '0;
        end
      end
      S_GAP: begin
        if (div_q == GAP_END) begin
          busy_d  = 1'b0;
          ready_d = 1'b1;
          mosi_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q    <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      txsh_q   <= '0;
      rxsh_q   <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      cs_q     <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      txrdy_q  <= 1'b0;
      rxdata_q <= '0;
      rxvld_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      txsh_q   <= txsh_d;
      rxsh_q   <= rxsh_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      cs_q     <= cs_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      txrdy_q  <= txrdy_d;
      rxdata_q <= rxdata_d;
      rxvld_q  <= rxvld_d;
      done_q   <= done_d;
    end
  end

  assign spi_sclk       = sclk_q;
  assign spi_mosi       = mosi_q;
  assign spi_cs         = cs_q;
  assign bus.ready_o    = ready_q;
  assign bus.busy_o     = busy_q;
  assign bus.tx_ready_o = txrdy_q;
  assign bus.rx_data_o  = rxdata_q;
  assign bus.rx_valid_o = rxvld_q;
  assign bus.done_o     = done_q;

endmodule

// File: tb/tb_spi_host.sv
// Randomized bench for spi_host: a driver queues expected MOSI/MISO bytes, a monitor
// checks the SPI waveform timing and the returned bytes against those expectations.
module tb_spi_host;
  localparam int unsigned CLK_DIV = 8;
  localparam int unsigned CS_GAP  = 8;
  localparam int unsigned BOUND   = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic spi_sclk, spi_mosi, spi_cs, spi_miso;
  logic slv_miso = 1'b0;
  bit   loop = 1'b0;

  spi_host_if bus ();

  spi_host #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .bus      (bus),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_cs   (spi_cs),
    .spi_miso (spi_miso)
  );

  assign spi_miso = loop ? spi_mosi : slv_miso;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  exp_mosi[$];
  logic [7:0]  exp_rx[$];
  logic [7:0]  slv_q[$];
  logic [7:0]  tx_buf[$];
  int unsigned acc_q[$];
  int unsigned len_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Responder: shifts its byte out MSB first, changing MISO on each rising SCLK.
  int unsigned sbit = 0;
  logic [7:0]  scur = '0;
  always @(posedge spi_sclk or posedge spi_cs) begin
    if (spi_cs) sbit = 0;
    else begin
      if (sbit == 0) scur = (slv_q.size() > 0 && !loop) ? slv_q.pop_front() : 8'h00;
      slv_miso = scur[7 - sbit];
      sbit = (sbit + 1) % 8;
    end
  end

  // Monitor
  logic p_sclk = 1'b0, p_cs = 1'b1, p_mosi = 1'b0, p_ready = 1'b1;
  bit          skip = 1'b1;
  int unsigned bitn = 0, bytes = 0, rises = 0, frame_len = 0;
  int unsigned hs_c = 0, f8_c = 0, last_rise = 0, last_fall = 0, done_c = 0, a_c = 0;
  int unsigned rises_tot = 0, hs_tot = 0, csf_tot = 0, ev_done = 0, ev_rxv = 0;
  logic [7:0]  sh = '0, e = '0;
  bit          rise, fall;

  always @(negedge clk) begin
    if (rst) begin
      bitn = 0; bytes = 0; rises = 0; skip = 1'b1;
    end else if (skip) begin
      skip = 1'b0;
    end else begin
      rise = spi_sclk && !p_sclk;
      fall = !spi_sclk && p_sclk;
      if (!spi_cs && p_cs) begin
        csf_tot++;
        chk("start_pending", acc_q.size(), 1);
        if (acc_q.size() > 0) begin
          a_c = acc_q.pop_front();
          frame_len = len_q.pop_front();
          chk("cs_fall_cycle", cyc, a_c + 1);
        end
        chk("tx_ready_at_cs", bus.tx_ready_o, 1);
        chk("busy_at_cs", bus.busy_o, 1);
        chk("ready_at_cs", bus.ready_o, 0);
        rises = 0; bytes = 0; bitn = 0;
      end
      if (bus.tx_ready_o) begin
        chk("stretch_sclk", spi_sclk, 0);
        chk("stretch_cs", spi_cs, 0);
      end
      if (bus.tx_valid_i && bus.tx_ready_o) begin
        hs_c = cyc;
        hs_tot++;
      end
      if (rise) begin
        rises++; rises_tot++;
        if (bitn == 0) begin
          chk("first_rise", cyc - hs_c, CLK_DIV);
          if (bytes > 0 && hs_c == f8_c + 1) chk("byte_gap", cyc - f8_c, CLK_DIV + 1);
        end else begin
          chk("low_half", cyc - last_fall, CLK_DIV);
        end
        last_rise = cyc;
      end
      if (fall) begin
        chk("high_half", cyc - last_rise, CLK_DIV);
        sh = {sh[6:0], spi_mosi};
        last_fall = cyc;
        bitn++;
        if (bitn == 8) begin
          bitn = 0; bytes++; f8_c = cyc;
          chk("mosi_pending", exp_mosi.size() > 0, 1);
          if (exp_mosi.size() > 0) begin
            e = exp_mosi.pop_front();
            chk("mosi_byte", sh, e);
          end
        end
      end
      if (spi_mosi != p_mosi && !spi_cs && !p_cs) chk("mosi_on_rise", rise, 1);
      if (bus.rx_valid_o) begin
        ev_rxv++;
        chk("rxv_cycle", cyc, f8_c + 1);
        chk("rx_pending", exp_rx.size() > 0, 1);
        if (exp_rx.size() > 0) begin
          e = exp_rx.pop_front();
          chk("rx_data", bus.rx_data_o, e);
        end
      end
      if (bus.done_o) begin
        ev_done++; done_c = cyc;
        chk("done_cycle", cyc, f8_c + CLK_DIV);
        chk("done_cs", spi_cs, 1);
        chk("rise_count", rises, 8 * (frame_len + 1));
        chk("byte_count", bytes, frame_len + 1);
      end
      if (spi_cs && !p_cs) chk("cs_rise_done", bus.done_o, 1);
      if (bus.ready_o && !p_ready) begin
        chk("ready_cycle", cyc, done_c + CS_GAP);
        chk("ready_busy", bus.busy_o, 0);
        chk("ready_mosi", spi_mosi, 0);
      end
    end
    p_sclk = spi_sclk; p_cs = spi_cs; p_mosi = spi_mosi; p_ready = bus.ready_o;
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cs"}, spi_cs, 1);
    chk({tag, "_sclk"}, spi_sclk, 0);
    chk({tag, "_mosi"}, spi_mosi, 0);
    chk({tag, "_ready"}, bus.ready_o, 1);
    chk({tag, "_busy"}, bus.busy_o, 0);
    chk({tag, "_tx_ready"}, bus.tx_ready_o, 0);
    chk({tag, "_rx_data"}, bus.rx_data_o, 0);
    chk({tag, "_rx_valid"}, bus.rx_valid_o, 0);
    chk({tag, "_done"}, bus.done_o, 0);
  endtask

  task automatic wait_ready(input string nm);
    int unsigned t = 0;
    @(negedge clk);
    while (!bus.ready_o && t < BOUND) begin @(negedge clk); t++; end
    chk(nm, t < BOUND, 1);
  endtask

  task automatic start_frame(input int unsigned len);
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.len_i   = 8'(len);
    @(negedge clk);
    acc_q.push_back(cyc);
    len_q.push_back(len);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.len_i   = 8'($urandom);
  endtask

  // Sends tx_buf[0..len]; stall_at drops valid for 50 cycles before that byte, poke_at pulses start mid-frame.
  task automatic send_frame(input int unsigned len, input bit lp, input int stall_at, input int poke_at);
    int unsigned t;
    logic [7:0] sb;
    wait_ready("idle_before_frame");
    loop = lp;
    start_frame(len);
    for (int i = 0; i <= int'(len); i++) begin
      if (i == stall_at) begin
        t = 0;
        @(negedge clk);
        while (!bus.tx_ready_o && t < BOUND) begin @(negedge clk); t++; end
        repeat (50) @(posedge clk);
        #1;
      end
      bus.tx_valid_i = 1'b1;
      bus.tx_data_i  = tx_buf[i];
      t = 0;
      @(negedge clk);
      while (!bus.tx_ready_o && t < BOUND) begin @(negedge clk); t++; end
      chk("handshake_wait", t < BOUND, 1);
      if (t >= BOUND) begin
        bus.tx_valid_i = 1'b0;
        return;
      end
      sb = 8'($urandom);
      exp_mosi.push_back(tx_buf[i]);
      if (!lp) slv_q.push_back(sb);
      exp_rx.push_back(lp ? tx_buf[i] : sb);
      @(posedge clk); #1;
      if (i == int'(len) || i + 1 == stall_at) bus.tx_valid_i = 1'b0;
      if (i == poke_at) begin
        bus.start_i = 1'b1;
        bus.len_i   = 8'd3;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
      end
    end
    bus.tx_valid_i = 1'b0;
    wait_ready("frame_complete");
  endtask

  initial begin
    int unsigned r0, d0, v0, c0, h0, t, len;
    int stall;
    bus.start_i = 1'b0;
    bus.len_i = '0;
    bus.tx_data_i = '0;
    bus.tx_valid_i = 1'b0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");

    tx_buf = '{8'hA5};
    send_frame(0, 1'b0, -1, -1);

    tx_buf = '{8'h12, 8'h34, 8'h56};
    send_frame(2, 1'b1, -1, -1);

    tx_buf = '{8'h9C, 8'h3E, 8'hF1};
    send_frame(2, 1'b0, 1, -1);

    // Reset partway through a byte
    wait_ready("idle_before_rst_frame");
    loop = 1'b0;
    start_frame(1);
    bus.tx_valid_i = 1'b1;
    bus.tx_data_i  = 8'h3C;
    t = 0;
    @(negedge clk);
    while (!bus.tx_ready_o && t < BOUND) begin @(negedge clk); t++; end
    chk("rst_hs_wait", t < BOUND, 1);
    exp_mosi.push_back(8'h3C);
    slv_q.push_back(8'hC3);
    exp_rx.push_back(8'hC3);
    r0 = rises_tot;
    @(posedge clk); #1 bus.tx_valid_i = 1'b0;
    t = 0;
    while (rises_tot < r0 + 4 && t < BOUND) begin @(negedge clk); t++; end
    chk("fourth_rise_wait", t < BOUND, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_mosi.delete(); exp_rx.delete(); slv_q.delete(); acc_q.delete(); len_q.delete();
    d0 = ev_done; v0 = ev_rxv;
    @(negedge clk);
    check_reset_vals("midrst");
    repeat (200) @(negedge clk);
    chk("no_done_after_rst", ev_done - d0, 0);
    chk("no_rxv_after_rst", ev_rxv - v0, 0);

    // Longest frame with a start request while busy
    tx_buf.delete();
    for (int i = 0; i < 256; i++) tx_buf.push_back(8'($urandom));
    d0 = ev_done; c0 = csf_tot; h0 = hs_tot; v0 = ev_rxv;
    send_frame(255, 1'b0, -1, 100);
    repeat (60) @(negedge clk);
    chk("max_one_done", ev_done - d0, 1);
    chk("max_one_frame", csf_tot - c0, 1);
    chk("max_handshakes", hs_tot - h0, 256);
    chk("max_rx_bytes", ev_rxv - v0, 256);

    for (int k = 0; k < 6; k++) begin
      len = $urandom_range(0, 4);
      tx_buf.delete();
      for (int i = 0; i <= int'(len); i++) tx_buf.push_back(8'($urandom));
      stall = (len > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, len)) : -1;
      send_frame(len, 1'($urandom_range(0, 1)), stall, -1);
    end

    repeat (20) @(negedge clk);
    chk("mosi_queue_drained", exp_mosi.size(), 0);
    chk("rx_queue_drained", exp_rx.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #(64'd10 * 64'd95000);
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/spi_host.md
# spi_host

SPI initiator that drives the chip's SPI slave port (register writes in `spi_mode`=0, sprite bitstream loads in `spi_mode`=1) from an on-board controller or test harness. It uses mode CPOL=0, CPHA=1, MSB first, 8-bit words and active-low chip select, which is the other end of the chip's receiver. A transaction is a chip-select frame of `len_i+1` bytes supplied through a valid/ready byte stream. Each byte received on MISO is returned on a byte output strobe.

## Interface

Parameters:
- `CLK_DIV`, default 8: system clocks per SCLK half-period. Legal range is 5 or more, because the responder synchronizes SCLK through 2 FFs and detects edges.
- `CS_GAP`, default 8: system clocks that CS stays high after a frame before `ready_o` rises again.

Ports:
- `clk_i`  in  1: system clock.
- `rst_i`  in  1: synchronous, active-high reset.
- `start_i`  in  1: request a frame. Accepted only on a cycle where `ready_o`=1.
- `len_i`  in  8: frame length minus 1 (1 to 256 bytes). Latched on accept.
- `ready_o`  out  1: idle, able to accept `start_i`.
- `busy_o`  out  1: frame in progress, from CS low through the end of the gap.
- `tx_data_i`  in  8: next byte to send.
- `tx_valid_i`  in  1: `tx_data_i` is valid.
- `tx_ready_o`  out  1: host takes `tx_data_i` when `tx_valid_i` and `tx_ready_o` are both 1.
- `rx_data_o`  out  8: last byte received on MISO.
- `rx_valid_o`  out  1: one-cycle strobe, `rx_data_o` updated.
- `done_o`  out  1: one-cycle strobe on the cycle CS returns high.
- `spi_sclk`  out  1: SPI clock, idles low.
- `spi_mosi`  out  1: SPI data out.
- `spi_cs`  out  1: chip select, active low.
- `spi_miso`  in  1: SPI data in.

## Operation

- All outputs are registered.
- Reset values: `spi_cs`=1, `spi_sclk`=0, `spi_mosi`=0, `ready_o`=1, `busy_o`=0, `tx_ready_o`=0, `rx_data_o`=0, `rx_valid_o`=0, `done_o`=0.
- States: IDLE → WAIT_BYTE → SHIFT_HI ↔ SHIFT_LO → (WAIT_BYTE | HOLD) → GAP → IDLE.
- **IDLE**
  - On `start_i` with `ready_o` set: latch `len_i` into the byte counter.
  - Set `spi_cs`=0, `ready_o`=0, `busy_o`=1.
  - Go to WAIT_BYTE.
- **WAIT_BYTE**
  - `tx_ready_o`=1 and `spi_sclk`=0.
  - On handshake: load the shift register and clear the bit counter (3 bits).
  - Start the divider. After `CLK_DIV` cycles, enter SHIFT_HI.
- **SHIFT_HI** (entry is a rising edge)
  - Drive `spi_sclk`=1 and the current MSB on `spi_mosi` on the same clock edge.
  - After `CLK_DIV` cycles: drive `spi_sclk`=0 and sample `spi_miso` into the rx shift register on that same edge. Enter SHIFT_LO.
- **SHIFT_LO**
  - Bit counter not 7: after `CLK_DIV` cycles, shift left, increment the bit counter, enter SHIFT_HI.
  - Bit counter 7 (8th falling edge):
    - Next cycle: `rx_data_o` takes the assembled byte and `rx_valid_o` pulses.
    - Byte counter ≠ 0: decrement it and enter WAIT_BYTE immediately (`tx_ready_o`=1).
    - Byte counter = 0: enter HOLD.
- **HOLD**
  - After `CLK_DIV` cycles: `spi_cs`=1 and `done_o`=1 for one cycle. Enter GAP.
- **GAP**
  - After `CS_GAP` cycles: `busy_o`=0, `ready_o`=1, IDLE.
- `spi_mosi` holds the last driven bit between bytes and returns to 0 in IDLE.

Boundary conditions:
- **TX underflow:** if `tx_valid_i` stays low in WAIT_BYTE, the host waits indefinitely with `spi_sclk`=0 and `spi_cs`=0. This is clock stretching and is legal.
- **Ignored requests:** `start_i` while `ready_o`=0 is ignored. `len_i` changes after accept have no effect.
- **Byte counter:** 8 bits, decrements only; `len_i`=255 gives exactly 256 bytes.
- **Reset mid-frame:**
  - The next cycle shows reset values on every output, including `spi_cs`=1.
  - No `done_o` and no `rx_valid_o` for the partial byte.
- **Reset vs. `start_i`:** when both occur in the same cycle, reset wins.

## Timing

- `start_i` accepted at cycle a → `spi_cs` low at a+1; `tx_ready_o`=1 from a+1.
- Handshake at cycle h → first rising SCLK at h+`CLK_DIV`.
- SCLK period is 2·`CLK_DIV`, 50% duty.
- MOSI changes only with rising SCLK and is stable ≥`CLK_DIV` cycles before the falling edge.
- Back-to-back bytes (`tx_valid_i` held high):
  - Handshake in the cycle after the 8th falling edge.
  - Next rising edge `CLK_DIV`+1 cycles after the 8th falling edge.
- 8th falling edge of the last byte at f → `spi_cs` high and `done_o` at f+`CLK_DIV`.
- `ready_o` returns at f+`CLK_DIV`+`CS_GAP`.
- `rx_valid_o` comes 1 cycle after each 8th falling edge.

## Test plan

1. **Reset:** hold `rst_i` 3 cycles mid-idle → `spi_cs`=1, `spi_sclk`=0, `spi_mosi`=0, `ready_o`=1, `busy_o`=0.
2. **Single byte:** `len_i`=0, byte 0xA5, `CLK_DIV`=8.
   - Required: CS low at a+1; exactly 8 SCLK rising edges.
   - MOSI sampled at the falling edges reads 1,0,1,0,0,1,0,1.
   - CS high and `done_o` 8 cycles after the 8th fall; `ready_o` 8 cycles later.
3. **Loopback:** `spi_miso` tied to `spi_mosi`, `len_i`=2, bytes 0x12,0x34,0x56 with valid held high.
   - Required: `rx_valid_o` pulses three times with 0x12, 0x34, 0x56.
   - Between bytes, 8th fall to next rise is 9 cycles.
4. **Stall:** drop `tx_valid_i` for 50 cycles before byte 2 → SCLK low and CS low throughout; first rise 8 cycles after the handshake.
5. **Reset mid-byte:** assert `rst_i` after the 4th rising edge.
   - Required next cycle: `spi_cs`=1, `spi_sclk`=0, `ready_o`=1.
   - No `done_o`; no `rx_valid_o`.
6. **Max length and busy start:** `len_i`=255 → 256 handshakes and 2048 rising edges. `start_i` pulsed mid-frame is ignored: one `done_o`, no second frame.
